multicycle_ctrl: RTL and testbench

Main control FSM for the multi-cycle RV32I variant of the core; sequences instruction fetch, decode, execute, memory access and writeback over several cycles, sharing one ALU and one memory port.
Drives datapath mux selects, write enables and the 2-bit ALU-op field consumed by the existing ALU decoder.
Adds a ready/request memory handshake with timeout-to-fault protection.

---
 rtl/multicycle_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_imm_dec.sv | 20 ++
 rtl/multicycle_ctrl.sv | 165 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states, opcodes
// and the select/op fields consumed by the ALU decoder and datapath.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_LINK     = 4'd12,
    S_LUI      = 4'd13,
    S_FAULT    = 4'd14
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_FUNCT  = 2'b10;
  localparam logic [1:0] ALU_LUI    = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // States that hold a memory request open and therefore run the timeout.
  function automatic logic is_mem_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_imm_dec.sv
// Immediate-format select decoded straight from the opcode (combinational).
module multicycle_imm_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      OP_LUI:    imm_src = IMM_U;
      default:   imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I main control FSM with memory-ready timeout and sticky fault.
// Optional performance counters are enabled by defining PERF_CNT_EN.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       fault,
  output logic [3:0] state_dbg
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
`endif
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  generate
    if (TIMEOUT < 1 || CNT_W < 1) begin : g_bad_param
      $error("multicycle_ctrl: TIMEOUT and CNT_W must be >= 1");
    end
  endgenerate

  state_e          state_q, state_d;
  logic [TO_W-1:0] to_q;
  logic            waiting;
  logic [2:0]      imm_src_raw;

  multicycle_imm_dec u_imm_dec (
    .op      (op),
    .imm_src (imm_src_raw)
  );

  always_comb begin
    state_d = state_q;
    waiting = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE; else waiting = 1'b1;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB; else waiting = 1'b1;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH; else waiting = 1'b1;
      S_EXECR, S_EXECI, S_LUI, S_JAL: state_d = S_ALUWB;
      S_ALUWB, S_BRANCH, S_LINK:      state_d = S_FETCH;
      S_JALR:     state_d = S_LINK;
      default:    state_d = S_FAULT;
    endcase
    // A ready in the last allowed cycle still completes; only a miss faults.
    if (waiting && to_q == TO_LAST) state_d = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) to_q <= '0;
      else if (waiting)       to_q <= to_q + 1'b1;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALU_ADD;
    fault      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1; alu_src_b = SRCB_FOUR; result_src = RES_ALURES;
        ir_write = mem_ready; pc_write = mem_ready;
      end
      S_DECODE:   begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_IMM; end
      S_MEMADR:   begin alu_src_a = SRCA_RD1; alu_src_b = SRCB_IMM; end
      S_MEMREAD:  begin mem_req = 1'b1; adr_src = 1'b1; end
      S_MEMWB:    begin result_src = RES_DATA; reg_write = 1'b1; end
      S_MEMWRITE: begin mem_req = 1'b1; mem_write = 1'b1; adr_src = 1'b1; end
      S_EXECR:    begin alu_src_a = SRCA_RD1; alu_op = ALU_FUNCT; end
      S_EXECI:    begin alu_src_a = SRCA_RD1; alu_src_b = SRCB_IMM; alu_op = ALU_FUNCT; end
      S_LUI:      begin alu_src_b = SRCB_IMM; alu_op = ALU_LUI; end
      S_ALUWB:    reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a = SRCA_RD1; alu_op = ALU_BRANCH; pc_write = branch_taken;
      end
      S_JAL:      begin alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_FOUR; pc_write = 1'b1; end
      S_JALR: begin
        alu_src_a = SRCA_RD1; alu_src_b = SRCB_IMM; result_src = RES_ALURES; pc_write = 1'b1;
      end
      S_LINK: begin
        alu_src_a = SRCA_OLDPC; alu_src_b = SRCB_FOUR; result_src = RES_ALURES; reg_write = 1'b1;
      end
      S_FAULT:    fault = 1'b1;
      default:    fault = 1'b0;
    endcase
    // Held reset masks every output so nothing writes in a reset cycle.
    if (!reset_n) begin
      mem_req = 1'b0; mem_write = 1'b0; adr_src = 1'b0; ir_write = 1'b0;
      pc_write = 1'b0; reg_write = 1'b0; result_src = '0; alu_src_a = '0;
      alu_src_b = '0; alu_op = '0; fault = 1'b0;
    end
  end

  assign imm_src   = reset_n ? imm_src_raw : 3'b000;
  assign state_dbg = reset_n ? state_q : 4'd0;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, instret_q;
  logic             retire;

  assign retire = (state_d == S_FETCH) &&
                  (state_q inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_LINK});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

  assign cycle_cnt   = reset_n ? cycle_q   : '0;
  assign instret_cnt = reset_n ? instret_q : '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl (TIMEOUT = 16).
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, fault;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state_dbg;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int          n_vec = 0;
  int          n_err = 0;
  logic [21:0] sb[$];
  logic [6:0]  op_cur = OP_RTYPE;
  logic        rstn_nxt = 1'b0;

  multicycle_ctrl #(.TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .branch_taken(branch_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .fault(fault), .state_dbg(state_dbg)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  function automatic logic [18:0] mk(input logic [3:0] st, input logic flt, req, wr, adr,
                                     ir, pc, rw, input logic [1:0] rs, a, b, alu);
    return {st, flt, req, wr, adr, ir, pc, rw, rs, a, b, alu};
  endfunction

  task automatic cyc(input string tag, input logic bt, input logic rdy, input logic [18:0] v);
    logic [21:0] got, exp;
    @(negedge clk);
    reset_n = rstn_nxt; op = op_cur; branch_taken = bt; mem_ready = rdy;
    sb.push_back(rstn_nxt ? {v, imm_of(op_cur)} : 22'd0);
    #1;
    got = {state_dbg, fault, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_op, imm_src};
    exp = sb.pop_front();
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rst_cyc();
    rstn_nxt = 1'b0; cyc("reset", 1'b0, 1'b1, 19'd0); rstn_nxt = 1'b1;
  endtask
  task automatic fetch(input logic r);
    cyc("fetch", 0, r, mk(S_FETCH, 0, 1, 0, 0, r, r, 0, 2'b10, 2'b00, 2'b10, 2'b00));
  endtask
  task automatic decode();
    cyc("decode", 0, 1, mk(S_DECODE, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00));
  endtask
  task automatic memadr();
    cyc("memadr", 0, 0, mk(S_MEMADR, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00));
  endtask
  task automatic memread(input logic r);
    cyc("memread", 0, r, mk(S_MEMREAD, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
  endtask
  task automatic memwb();
    cyc("memwb", 0, 0, mk(S_MEMWB, 0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00));
  endtask
  task automatic memwrite(input logic r);
    cyc("memwrite", 0, r, mk(S_MEMWRITE, 0, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
  endtask
  task automatic execr();
    cyc("execr", 0, 0, mk(S_EXECR, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10));
  endtask
  task automatic execi();
    cyc("execi", 0, 0, mk(S_EXECI, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10));
  endtask
  task automatic lui();
    cyc("lui", 0, 0, mk(S_LUI, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 2'b11));
  endtask
  task automatic aluwb();
    cyc("aluwb", 0, 1, mk(S_ALUWB, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00));
  endtask
  task automatic branch(input logic t);
    cyc("branch", t, 0, mk(S_BRANCH, 0, 0, 0, 0, 0, t, 0, 2'b00, 2'b10, 2'b00, 2'b01));
  endtask
  task automatic jal();
    cyc("jal", 0, 0, mk(S_JAL, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00));
  endtask
  task automatic jalr();
    cyc("jalr", 0, 0, mk(S_JALR, 0, 0, 0, 0, 0, 1, 0, 2'b10, 2'b10, 2'b01, 2'b00));
  endtask
  task automatic link();
    cyc("link", 0, 0, mk(S_LINK, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b01, 2'b10, 2'b00));
  endtask
  task automatic flt(input logic r);
    cyc("fault", r, r, mk(S_FAULT, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00));
  endtask

  initial begin
    rst_cyc(); rst_cyc();
    op_cur = OP_RTYPE;  fetch(1); decode(); execr(); aluwb();
    op_cur = OP_LOAD;   fetch(1); decode(); memadr();
    memread(0); memread(0); memread(0); memread(1); memwb();
    op_cur = OP_STORE;  fetch(1); decode(); memadr(); memwrite(0); memwrite(1);
    op_cur = OP_BRANCH; fetch(1); decode(); branch(0);
    fetch(1); decode(); branch(1);
    op_cur = OP_JAL;    fetch(1); decode(); jal(); aluwb();
    op_cur = OP_JALR;   fetch(1); decode(); jalr(); link();
    op_cur = OP_LUI;    fetch(1); decode(); lui(); aluwb();
    op_cur = OP_ITYPE;  fetch(1); decode(); execi(); aluwb();
    // ready on the 16th waiting cycle still completes the fetch
    op_cur = OP_RTYPE;
    for (int i = 0; i < 15; i++) fetch(0);
    fetch(1); decode(); execr(); aluwb();
    // ready never arrives: FAULT after exactly 16 cycles
    for (int i = 0; i < 16; i++) fetch(0);
    flt(0); flt(1); flt(0);
    rst_cyc(); fetch(1);
    // illegal opcode
    op_cur = 7'b1111111; decode();
    for (int i = 0; i < 10; i++) flt(i[0]);
    rst_cyc(); op_cur = OP_LOAD; fetch(1); decode(); memadr(); memread(0);
    // reset in the middle of a load abandons it
    rst_cyc(); fetch(1); decode(); memadr(); memread(1); memwb();
`ifdef PERF_CNT_EN
    rst_cyc();
    op_cur = OP_ITYPE;
    for (int i = 0; i < 3; i++) begin fetch(1); decode(); execi(); aluwb(); end
    @(negedge clk); #1;
    n_vec++;
    assert (cycle_cnt === 32'd12) else begin
      n_err++; $error("FAIL cycle_cnt: observed %0d expected 12", cycle_cnt);
    end
    n_vec++;
    assert (instret_cnt === 32'd3) else begin
      n_err++; $error("FAIL instret_cnt: observed %0d expected 3", instret_cnt);
    end
    rst_cyc(); fetch(1); decode(); rst_cyc(); fetch(1);
    n_vec++;
    assert (cycle_cnt === 32'd0 && instret_cnt === 32'd0) else begin
      n_err++; $error("FAIL perf_clear: observed %0d/%0d expected 0/0", cycle_cnt, instret_cnt);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
